timer_share_sched: RTL and testbench
====================================

# timer_share_sched

Sequencer and round-robin arbiter that shares one 16-bit-register interval timer peripheral among `NUM_REQ` requesters. It is an Avalon-MM write master on the timer's register slave and sits between the timer and software/hardware clients that need one-shot delays. Each granted client gets exclusive use of the timer for one one-shot interval. The block programs the period, starts the timer, waits for `irq`, clears and stops the timer, then returns a `done` pulse.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `IDW`, default 2: width of `active_id`, equal to clog2(`NUM_REQ`).
- `clk` in 1: single clock, shared with the timer.
- `reset_n` in 1: reset, asynchronous assert, active-low.
- `req` in `NUM_REQ`: level request per client; held until that client's `done`.
- `period` in `NUM_REQ`*32: client i's tick count P, occupying bits [32i+31:32i]; sampled at grant.
- `done` out `NUM_REQ`: one-cycle pulse to the granted client when its interval has expired.
- `busy` out 1: high in every state except IDLE.
- `active_id` out `IDW`: index of the granted client; valid while `busy`.
- `t_address` out 3: timer register index. 0 status, 1 control, 2 period_l, 3 period_h.
- `t_chipselect` out 1: timer select.
- `t_write_n` out 1: active-low write strobe.
- `t_writedata` out 16: timer write data.
- `t_irq` in 1: timer interrupt.

## Operation
- Reset values: `done`=0, `t_chipselect`=0, `t_write_n`=1, `t_address`=0, `t_writedata`=0, `active_id`=0. RR pointer = 0. State = INIT_STOP, so `busy`=1 out of reset.
- Every bus access is a single-cycle write with `t_chipselect`=1 and `t_write_n`=0. The timer has no waitrequest. The block never issues reads.
- FSM states and writes:
  - INIT_STOP: write control=0x0008 (STOP, ITO=0, CONT=0). Go to INIT_CLR.
  - INIT_CLR: write status=0. Go to IDLE.
  - IDLE: if `req`≠0, go to ARB.
  - ARB: grant the first set `req` bit at or after the RR pointer, wrapping. Latch `active_id` and L = max(P,1)−1 (32-bit). Set RR pointer = grant+1 mod `NUM_REQ`.
  - WR_PL: write period_l=L[15:0].
  - WR_PH: write period_h=L[31:16].
  - WR_CTRL: write control=0x0005 (START, ITO). Must immediately follow WR_PH.
  - WAIT_IRQ: stay here until `t_irq`=1. `req` changes are ignored.
  - CLR_STAT: write status=0.
  - STOP: write control=0x0008.
  - DONE: pulse `done[active_id]`. Go to IDLE.
- P=0 is treated as P=1. P=0xFFFFFFFF gives L=0xFFFFFFFE; no overflow.
- If the granted client drops `req` during service, the interval still completes and `done` still pulses. Clients must ignore an unexpected `done`.
- `t_irq` seen outside WAIT_IRQ is ignored. The next CLR_STAT clears it.
- `reset_n` asserted mid-operation: everything returns to reset values and the FSM re-runs INIT_STOP and INIT_CLR, so a timer left running is stopped.

## Timing
- Cycle numbers below are relative to the ARB cycle, a = 0.
- WR_PL at 1, WR_PH at 2, WR_CTRL at 3.
- The timer counter holds L from cycle 4 and reaches 0 at cycle P+3.
- `t_irq` rises at P+4. CLR_STAT at P+5, STOP at P+6, `done` at P+7. End-to-end latency is P+7 cycles.
- Back-to-back service: DONE, IDLE, then ARB. That is 2 cycles from `done` to the next grant.
- Fairness: each pending client waits at most `NUM_REQ`−1 intervals.

## Structure
- Shared package `timer_regs_pkg`:
  - address constants `TMR_STATUS`=0, `TMR_CONTROL`=1, `TMR_PERIODL`=2, `TMR_PERIODH`=3.
  - control bit constants ITO=0, CONT=1, START=2, STOP=3.
  - FSM state enum.
- One sub-module, `rr_arbiter`: combinational; inputs `req` and pointer, outputs grant index and `valid`.

## Test plan
- Reset, then observe: first two accesses are writes control=0x0008 then status=0; the FSM reaches IDLE by cycle 3.
- `req`=0001 with P=10 -> writes period_l=9, period_h=0, control=0x0005; `done`[0] pulses 17 cycles after ARB.
- `req`=1111 held, all P=3 -> grant order 0,1,2,3,0; each `done` 10 cycles after its ARB.
- Client 2 with P=0x00012345 -> period_l=0x2344, period_h=0x0001. Client 1 with P=0 -> L=0, `done` at 8 cycles.
- `reset_n` pulsed during WAIT_IRQ -> `done` stays 0; INIT writes repeat; the timer is stopped and `t_irq` stays low.
- Client 3 drops `req` in WAIT_IRQ while client 0 is pending -> `done`[3] still pulses; the next grant is client 0.

Source files
------------

// File: rtl/timer_regs_pkg.sv
// rtl/timer_regs_pkg.sv - timer register map, control bits and sequencer states
package timer_regs_pkg;

    // Register indices on the timer slave
    localparam logic [2:0] TMR_STATUS  = 3'd0;
    localparam logic [2:0] TMR_CONTROL = 3'd1;
    localparam logic [2:0] TMR_PERIODL = 3'd2;
    localparam logic [2:0] TMR_PERIODH = 3'd3;

    // Control register bit positions
    localparam int ITO   = 0;
    localparam int CONT  = 1;
    localparam int START = 2;
    localparam int STOP  = 3;

    // Control words: halt the counter, or start a one-shot with interrupt
    localparam logic [15:0] CTRL_HALT_VAL = 16'(1 << STOP);
    localparam logic [15:0] CTRL_RUN_VAL  = 16'((1 << START) | (1 << ITO));

    typedef enum logic [3:0] {
        ST_INIT_STOP,
        ST_INIT_CLR,
        ST_IDLE,
        ST_ARB,
        ST_WR_PL,
        ST_WR_PH,
        ST_WR_CTRL,
        ST_WAIT_IRQ,
        ST_CLR_STAT,
        ST_STOP,
        ST_DONE
    } sched_state_t;

endpackage

// File: rtl/timer_share_sched_if.sv
// rtl/timer_share_sched_if.sv - write-only register bus to the shared interval timer
interface timer_share_sched_if;
    logic [2:0]  t_address;
    logic        t_chipselect;
    logic        t_write_n;
    logic [15:0] t_writedata;
    logic        t_irq;

    modport master (
        output t_address,
        output t_chipselect,
        output t_write_n,
        output t_writedata,
        input  t_irq
    );

    modport slave (
        input  t_address,
        input  t_chipselect,
        input  t_write_n,
        input  t_writedata,
        output t_irq
    );
endinterface

// File: rtl/timer_share_sched_rr_arbiter.sv
// rtl/timer_share_sched_rr_arbiter.sv - combinational round-robin pick starting at a pointer
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDW-1:0]     i_ptr,
    output logic [IDW-1:0]     o_grant,
    output logic               o_valid
);

    logic [IDW-1:0] w_idx;

    // Scan from the farthest candidate down so the nearest set bit at/after the pointer wins
    always_comb begin
        o_grant = '0;
        o_valid = 1'b0;
        w_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = IDW'((int'(i_ptr) + k) % NUM_REQ);
            if (i_req[w_idx]) begin
                o_grant = w_idx;
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_share_sched.sv
// rtl/timer_share_sched.sv - shares one interval timer among requesters, one one-shot interval per grant
module timer_share_sched
    import timer_regs_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*32-1:0]  period,
    output logic [NUM_REQ-1:0]     done,
    output logic                   busy,
    output logic [IDW-1:0]         active_id,
    timer_share_sched_if.master    tmr
);

    sched_state_t       r_state;
    sched_state_t       w_state_next;
    logic               r_started;
    logic [IDW-1:0]     r_ptr;
    logic [IDW-1:0]     r_aid;
    logic [31:0]        r_len;
    logic               r_cs;
    logic [2:0]         r_addr;
    logic [15:0]        r_wdata;
    logic [NUM_REQ-1:0] r_done;

    logic [IDW-1:0]     w_grant;
    logic               w_valid;
    logic [31:0]        w_period;
    logic [31:0]        w_len;
    logic               w_cs;
    logic [2:0]         w_addr;
    logic [15:0]        w_wdata;
    logic [31:0]        w_per_arr [NUM_REQ];

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_arb (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_valid (w_valid)
    );

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_per
        assign w_per_arr[i] = period[32*i +: 32];
    end

    // Reload value: a zero period behaves as a single tick
    assign w_period = w_per_arr[w_grant];
    assign w_len    = (w_period == 32'd0) ? 32'd0 : w_period - 32'd1;

    // Next-state: INIT_STOP is held one extra cycle so its write lands after reset release
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_INIT_STOP: if (r_started) w_state_next = ST_INIT_CLR;
            ST_INIT_CLR:  w_state_next = ST_IDLE;
            ST_IDLE:      if (|req) w_state_next = ST_ARB;
            ST_ARB:       w_state_next = w_valid ? ST_WR_PL : ST_IDLE;
            ST_WR_PL:     w_state_next = ST_WR_PH;
            ST_WR_PH:     w_state_next = ST_WR_CTRL;
            ST_WR_CTRL:   w_state_next = ST_WAIT_IRQ;
            ST_WAIT_IRQ:  if (tmr.t_irq) w_state_next = ST_CLR_STAT;
            ST_CLR_STAT:  w_state_next = ST_STOP;
            ST_STOP:      w_state_next = ST_DONE;
            ST_DONE:      w_state_next = ST_IDLE;
            default:      w_state_next = ST_INIT_STOP;
        endcase
    end

    // Bus write decoded from the state being entered, so it is registered glitch-free
    always_comb begin
        w_cs    = 1'b0;
        w_addr  = TMR_STATUS;
        w_wdata = 16'h0000;
        case (w_state_next)
            ST_INIT_STOP, ST_STOP: begin
                w_cs    = 1'b1;
                w_addr  = TMR_CONTROL;
                w_wdata = CTRL_HALT_VAL;
            end
            ST_INIT_CLR, ST_CLR_STAT: begin
                w_cs    = 1'b1;
                w_addr  = TMR_STATUS;
            end
            ST_WR_PL: begin
                w_cs    = 1'b1;
                w_addr  = TMR_PERIODL;
                w_wdata = w_len[15:0];
            end
            ST_WR_PH: begin
                w_cs    = 1'b1;
                w_addr  = TMR_PERIODH;
                w_wdata = r_len[31:16];
            end
            ST_WR_CTRL: begin
                w_cs    = 1'b1;
                w_addr  = TMR_CONTROL;
                w_wdata = CTRL_RUN_VAL;
            end
            default: ;
        endcase
    end

    // State register, grant latch and round-robin pointer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_INIT_STOP;
            r_started <= 1'b0;
            r_ptr     <= '0;
            r_aid     <= '0;
            r_len     <= '0;
        end else begin
            r_state   <= w_state_next;
            r_started <= 1'b1;
            if (r_state == ST_ARB && w_valid) begin
                r_aid <= w_grant;
                r_len <= w_len;
                r_ptr <= (w_grant == IDW'(NUM_REQ - 1)) ? '0 : w_grant + 1'b1;
            end
        end
    end

    // Registered bus strobes and done pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cs    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_done  <= '0;
        end else begin
            r_cs    <= w_cs;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_done  <= (w_state_next == ST_DONE) ? (NUM_REQ'(1) << r_aid) : '0;
        end
    end

    assign tmr.t_chipselect = r_cs;
    assign tmr.t_write_n    = ~r_cs;
    assign tmr.t_address    = r_addr;
    assign tmr.t_writedata  = r_wdata;
    assign done             = r_done;
    assign busy             = (r_state != ST_IDLE);
    assign active_id        = r_aid;

endmodule

// File: tb/tb_timer_share_sched.sv
// tb/tb_timer_share_sched.sv - randomized and directed checks of timer_share_sched against a behavioural model
module tb_timer_share_sched;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*32-1:0] period = '0;
    logic [N-1:0]   done;
    logic           busy;
    logic [1:0]     active_id;

    timer_share_sched_if bus();

    timer_share_sched #(.NUM_REQ(N), .IDW(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .period    (period),
        .done      (done),
        .busy      (busy),
        .active_id (active_id),
        .tmr       (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Interval timer peripheral model (not reset by reset_n)
    logic        tm_run = 1'b0;
    logic        tm_ito = 1'b0;
    logic        tm_irq = 1'b0;
    logic [15:0] tm_pl  = 16'h0;
    logic [15:0] tm_ph  = 16'h0;
    logic [31:0] tm_cnt = 32'h0;

    assign bus.t_irq = tm_irq;

    always @(posedge clk) begin
        if (bus.t_chipselect && !bus.t_write_n) begin
            case (bus.t_address)
                3'd0: tm_irq <= 1'b0;
                3'd1: begin
                    if (bus.t_writedata[3]) tm_run <= 1'b0;
                    else if (bus.t_writedata[2]) begin
                        tm_run <= 1'b1;
                        tm_ito <= bus.t_writedata[0];
                        tm_cnt <= {tm_ph, tm_pl};
                    end
                end
                3'd2: tm_pl <= bus.t_writedata;
                3'd3: tm_ph <= bus.t_writedata;
                default: ;
            endcase
        end else if (tm_run) begin
            if (tm_cnt == 32'd0) begin
                tm_run <= 1'b0;
                if (tm_ito) tm_irq <= 1'b1;
            end else begin
                tm_cnt <= tm_cnt - 32'd1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Bus/write log used by the literal checks
    int w_addr_q[$];
    int w_data_q[$];
    int w_cyc_q[$];
    int d_idx_q[$];
    int d_cyc_q[$];

    always @(negedge clk) begin
        if (reset_n && bus.t_chipselect && !bus.t_write_n) begin
            w_addr_q.push_back(int'(bus.t_address));
            w_data_q.push_back(int'(bus.t_writedata));
            w_cyc_q.push_back(cyc);
        end
        for (int i = 0; i < N; i++) begin
            if (reset_n && done[i]) begin
                d_idx_q.push_back(i);
                d_cyc_q.push_back(cyc);
            end
        end
    end

    task automatic clear_logs();
        w_addr_q.delete(); w_data_q.delete(); w_cyc_q.delete();
        d_idx_q.delete();  d_cyc_q.delete();
    endtask

    // ---------------- behavioural model / compare process ----------------
    task automatic chk_reset();
        check("rst_chipselect", bus.t_chipselect, 0);
        check("rst_write_n", bus.t_write_n, 1);
        check("rst_address", bus.t_address, 0);
        check("rst_writedata", bus.t_writedata, 0);
        check("rst_done", done, 0);
        check("rst_active_id", active_id, 0);
        check("rst_busy", busy, 1);
    endtask

    task automatic chk_cyc(input logic cs, input logic [2:0] a, input logic [15:0] d,
                           input logic [N-1:0] dn, input logic bsy, input bit aid_en,
                           input logic [1:0] aid);
        check("chipselect", bus.t_chipselect, cs);
        check("write_n", bus.t_write_n, !cs);
        if (cs) begin
            check("address", bus.t_address, a);
            check("writedata", bus.t_writedata, d);
        end
        check("done", done, dn);
        check("busy", busy, bsy);
        if (aid_en) check("active_id", active_id, aid);
    endtask

    task automatic adv(output bit ab);
        @(negedge clk);
        ab = !reset_n;
        if (ab) chk_reset();
    endtask

    // Called at the first sample after reset release; returns when reset reasserts
    task automatic run_model();
        bit ab;
        int ptr;
        int g;
        longint pe;
        logic [31:0] p;
        logic [31:0] l;
        logic [N-1:0] oh;
        ptr = 0;
        chk_cyc(0, 3'd0, 16'h0, '0, 1, 0, 2'd0);
        adv(ab); if (ab) return;
        chk_cyc(1, 3'd1, 16'h0008, '0, 1, 0, 2'd0);
        adv(ab); if (ab) return;
        chk_cyc(1, 3'd0, 16'h0000, '0, 1, 0, 2'd0);
        adv(ab); if (ab) return;
        forever begin
            chk_cyc(0, 3'd0, 16'h0, '0, 0, 0, 2'd0);
            check("idle_timer_run", tm_run, 0);
            check("idle_irq", tm_irq, 0);
            if (req == '0) begin
                adv(ab); if (ab) return;
                continue;
            end
            adv(ab); if (ab) return;
            chk_cyc(0, 3'd0, 16'h0, '0, 1, 0, 2'd0);
            g = -1;
            for (int k = 0; k < N; k++)
                if (g < 0 && req[(ptr + k) % N]) g = (ptr + k) % N;
            if (g >= 0) begin
                p   = period[32*g +: 32];
                pe  = (p == 32'd0) ? 64'd1 : longint'(p);
                l   = 32'(pe - 1);
                ptr = (g + 1) % N;
            end
            adv(ab); if (ab) return;
            if (g < 0) continue;
            chk_cyc(1, 3'd2, l[15:0], '0, 1, 1, g[1:0]);
            adv(ab); if (ab) return;
            chk_cyc(1, 3'd3, l[31:16], '0, 1, 1, g[1:0]);
            adv(ab); if (ab) return;
            chk_cyc(1, 3'd1, 16'h0005, '0, 1, 1, g[1:0]);
            for (longint k = 4; k <= pe + 4; k++) begin
                adv(ab); if (ab) return;
                chk_cyc(0, 3'd0, 16'h0, '0, 1, 1, g[1:0]);
                check("irq_timing", tm_irq, (k == pe + 4));
            end
            adv(ab); if (ab) return;
            chk_cyc(1, 3'd0, 16'h0000, '0, 1, 1, g[1:0]);
            adv(ab); if (ab) return;
            chk_cyc(1, 3'd1, 16'h0008, '0, 1, 1, g[1:0]);
            adv(ab); if (ab) return;
            oh = '0;
            oh[g] = 1'b1;
            chk_cyc(0, 3'd0, 16'h0, oh, 1, 1, g[1:0]);
            adv(ab); if (ab) return;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) chk_reset();
            else run_model();
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_p(input int i, input logic [31:0] p);
        period[32*i +: 32] = p;
    endtask

    task automatic wait_dones(input int n, input int budget);
        int c = 0;
        while (d_idx_q.size() < n && c < budget) begin
            @(posedge clk); #1;
            c++;
        end
        check("done_wait_in_budget", (d_idx_q.size() >= n), 1);
    endtask

    task automatic wait_writes(input int n, input int budget);
        int c = 0;
        while (w_addr_q.size() < n && c < budget) begin
            @(posedge clk); #1;
            c++;
        end
        check("write_wait_in_budget", (w_addr_q.size() >= n), 1);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    function automatic int arb_cyc(input int n);
        int seen = 0;
        foreach (w_addr_q[i]) begin
            if (w_addr_q[i] == 2) begin
                if (seen == n) return w_cyc_q[i] - 1;
                seen++;
            end
        end
        return -1000;
    endfunction

    initial begin
        int served;
        int budget;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (5) @(posedge clk); #1;
        check("lit_init_w0_addr", w_addr_q[0], 1);
        check("lit_init_w0_data", w_data_q[0], 16'h0008);
        check("lit_init_w1_addr", w_addr_q[1], 0);
        check("lit_init_w1_data", w_data_q[1], 0);
        check("lit_init_gap", w_cyc_q[1] - w_cyc_q[0], 1);

        // single client, P=10
        clear_logs();
        set_p(0, 32'd10);
        req = 4'b0001;
        wait_dones(1, 100);
        req = '0;
        check("lit_p10_pl", w_data_q[0], 9);
        check("lit_p10_ph", w_data_q[1], 0);
        check("lit_p10_ctrl_addr", w_addr_q[2], 1);
        check("lit_p10_ctrl", w_data_q[2], 5);
        check("lit_p10_latency", d_cyc_q[0] - arb_cyc(0), 17);

        // all four held, P=3, from a fresh pointer
        pulse_reset();
        repeat (5) @(posedge clk); #1;
        clear_logs();
        for (int i = 0; i < N; i++) set_p(i, 32'd3);
        req = 4'b1111;
        wait_dones(5, 200);
        req = '0;
        for (int i = 0; i < 5; i++) begin
            check("lit_rr_order", d_idx_q[i], i % N);
            check("lit_rr_latency", d_cyc_q[i] - arb_cyc(i), 10);
        end
        check("lit_rr_gap", arb_cyc(1) - d_cyc_q[0], 2);

        // zero period on client 1
        clear_logs();
        set_p(1, 32'd0);
        req = 4'b0010;
        wait_dones(1, 50);
        req = '0;
        check("lit_p0_pl", w_data_q[0], 0);
        check("lit_p0_ph", w_data_q[1], 0);
        check("lit_p0_latency", d_cyc_q[0] - arb_cyc(0), 8);
        check("lit_p0_idx", d_idx_q[0], 1);

        // client 3 drops req while waiting, client 0 pending
        clear_logs();
        set_p(3, 32'd5);
        set_p(0, 32'd4);
        req = 4'b1001;
        wait_writes(3, 20);
        repeat (2) @(posedge clk); #1;
        req[3] = 1'b0;
        wait_dones(2, 100);
        req = '0;
        check("lit_drop_first", d_idx_q[0], 3);
        check("lit_drop_next", d_idx_q[1], 0);

        // randomized arrivals; clients release on their done
        clear_logs();
        served = 0;
        budget = 0;
        while (served < 40 && budget < 3000) begin
            @(posedge clk); #1;
            budget++;
            while (d_idx_q.size() > served) begin
                req[d_idx_q[served]] = 1'b0;
                served++;
            end
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 5) == 0) begin
                    set_p(i, 32'($urandom_range(0, 12)));
                    req[i] = 1'b1;
                end
            end
        end
        check("random_services", (served >= 40), 1);
        req = '0;
        repeat (30) @(posedge clk); #1;

        // large period, reset during the interval
        clear_logs();
        set_p(2, 32'h00012345);
        req = 4'b0100;
        wait_writes(3, 20);
        repeat (4) @(posedge clk); #1;
        check("lit_big_pl", w_data_q[0], 16'h2344);
        check("lit_big_ph", w_data_q[1], 16'h0001);
        check("lit_big_running", tm_run, 1);
        @(posedge clk); #1 reset_n = 1'b0;
        clear_logs();
        req = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (8) @(posedge clk); #1;
        check("lit_rst_no_done", d_idx_q.size(), 0);
        check("lit_rst_w0_data", w_data_q[0], 16'h0008);
        check("lit_rst_w0_addr", w_addr_q[0], 1);
        check("lit_rst_w1_addr", w_addr_q[1], 0);
        check("lit_rst_timer_stopped", tm_run, 0);
        check("lit_rst_irq_low", tm_irq, 0);

        // maximum period
        clear_logs();
        set_p(1, 32'hFFFFFFFF);
        req = 4'b0010;
        wait_writes(3, 20);
        check("lit_max_pl", w_data_q[0], 16'hFFFE);
        check("lit_max_ph", w_data_q[1], 16'hFFFF);
        @(posedge clk); #1 reset_n = 1'b0;
        req = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (8) @(posedge clk); #1;
        check("lit_max_stopped", tm_run, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
